// File: rtl/counter_arb_ctrl.sv
// Round-robin arbiter and run sequencer for the shared 3-bit binary/Gray counter.
// Define COUNTER_ARB_SEQ_CHECK_EN to build the sticky output-sequence checker (seq_err).
module counter_arb_ctrl #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [1:0]       req_mode,
    input  logic [LEN_W-1:0] req_len0,
    input  logic [LEN_W-1:0] req_len1,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic [2:0]       result,
    output logic             busy,
    output logic             ctr_reset,
    output logic             ctr_mode,
    input  logic [2:0]       ctr_count,
    input  logic             err_clr,
    output logic             seq_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    state_t           state_reg, state_next;
    logic             last_reg, last_next;
    logic [LEN_W-1:0] len_reg, len_next;
    logic [LEN_W-1:0] step_reg, step_next;
    logic [1:0]       gnt_reg, gnt_next;
    logic             ctr_mode_reg, ctr_mode_next;
    logic [2:0]       result_reg, result_next;

    logic [2*LEN_W-1:0] len_flat;
    logic [LEN_W-1:0]   len_in [2];
    logic               win_owner;

    assign len_flat = {req_len1, req_len0};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign len_in[gi] = len_flat[gi*LEN_W +: LEN_W];
            assign done[gi]   = (state_reg == ST_DONE) && gnt_reg[gi];
        end
    endgenerate

    // On a tie the requester that did not win last time gets the counter.
    always_comb begin
        win_owner = 1'b0;
        case (req)
            2'b01:   win_owner = 1'b0;
            2'b10:   win_owner = 1'b1;
            2'b11:   win_owner = ~last_reg;
            default: win_owner = 1'b0;
        endcase
    end

    always_comb begin
        state_next    = state_reg;
        last_next     = last_reg;
        len_next      = len_reg;
        step_next     = step_reg;
        gnt_next      = gnt_reg;
        ctr_mode_next = ctr_mode_reg;
        result_next   = result_reg;
        case (state_reg)
            ST_IDLE: begin
                if (|req) begin
                    last_next     = win_owner;
                    len_next      = len_in[win_owner];
                    ctr_mode_next = req_mode[win_owner];
                    gnt_next      = win_owner ? 2'b10 : 2'b01;
                    step_next     = '0;
                    state_next    = (len_in[win_owner] == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                step_next = step_reg + ONE;
                if (step_reg == len_reg - ONE) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                result_next = ctr_count;
                gnt_next    = 2'b00;
                step_next   = '0;
                state_next  = ST_IDLE;
            end
            default: begin
                gnt_next   = 2'b00;
                state_next = ST_IDLE;
            end
        endcase
    end

    // last_reg resets to 1 so the first tie goes to requester 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            last_reg     <= 1'b1;
            len_reg      <= '0;
            step_reg     <= '0;
            gnt_reg      <= 2'b00;
            ctr_mode_reg <= 1'b0;
            result_reg   <= 3'd0;
        end else begin
            state_reg    <= state_next;
            last_reg     <= last_next;
            len_reg      <= len_next;
            step_reg     <= step_next;
            gnt_reg      <= gnt_next;
            ctr_mode_reg <= ctr_mode_next;
            result_reg   <= result_next;
        end
    end

    assign gnt       = gnt_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign ctr_reset = (state_reg != ST_RUN);
    assign ctr_mode  = ctr_mode_reg;
    assign result    = (state_reg == ST_DONE) ? ctr_count : result_reg;

`ifdef COUNTER_ARB_SEQ_CHECK_EN
    function automatic logic [2:0] seq3(input logic [2:0] k, input logic gray);
        return gray ? (k ^ (k >> 1)) : k;
    endfunction

    logic [2:0] exp_count;
    logic       mismatch;
    logic       seq_err_reg, seq_err_next;

    // step_reg equals j-1 in RUN cycle j, which is the value the counter should show.
    always_comb begin
        exp_count = 3'd0;
        mismatch  = 1'b0;
        case (state_reg)
            ST_RUN: begin
                exp_count = seq3(3'(step_reg), ctr_mode_reg);
                mismatch  = (ctr_count != exp_count);
            end
            ST_DONE: begin
                exp_count = seq3(3'(len_reg), ctr_mode_reg);
                mismatch  = (ctr_count != exp_count);
            end
            default: begin
                exp_count = 3'd0;
                mismatch  = 1'b0;
            end
        endcase
        seq_err_next = mismatch | (seq_err_reg & ~err_clr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seq_err_reg <= 1'b0;
        end else begin
            seq_err_reg <= seq_err_next;
        end
    end

    assign seq_err = seq_err_reg;
`else
    logic err_clr_unused;
    assign err_clr_unused = err_clr;
    assign seq_err        = 1'b0;
`endif

endmodule

// File: tb/tb_counter_arb_ctrl.sv
// Directed bench for counter_arb_ctrl with a behavioural model of the shared counter.
module tb_counter_arb_ctrl;
    localparam int LEN_W = 4;
`ifdef COUNTER_ARB_SEQ_CHECK_EN
    localparam logic SEQ_EN = 1'b1;
`else
    localparam logic SEQ_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [1:0]       req = 2'b00;
    logic [1:0]       req_mode = 2'b00;
    logic [LEN_W-1:0] req_len0 = '0;
    logic [LEN_W-1:0] req_len1 = '0;
    logic [1:0]       gnt, done;
    logic [2:0]       result;
    logic             busy, ctr_reset, ctr_mode;
    logic [2:0]       ctr_count;
    logic             err_clr = 1'b0;
    logic             seq_err;

    always #5 clk = ~clk;

    counter_arb_ctrl #(.LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .req(req), .req_mode(req_mode),
        .req_len0(req_len0), .req_len1(req_len1), .gnt(gnt), .done(done),
        .result(result), .busy(busy), .ctr_reset(ctr_reset), .ctr_mode(ctr_mode),
        .ctr_count(ctr_count), .err_clr(err_clr), .seq_err(seq_err)
    );

    // Shared counter: sync reset, binary core, Gray-coded output in mode 1.
    logic [2:0] k_reg = 3'd0;
    logic       force_en = 1'b0;
    logic [2:0] force_val = 3'd0;
    always @(posedge clk) begin
        if (ctr_reset) k_reg <= 3'd0;
        else           k_reg <= k_reg + 3'd1;
    end
    assign ctr_count = force_en ? force_val : (ctr_mode ? (k_reg ^ (k_reg >> 1)) : k_reg);

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] seq(input int k, input logic g);
        logic [2:0] b;
        b = 3'(k);
        return g ? (b ^ (b >> 1)) : b;
    endfunction

    typedef struct {
        logic [1:0]       req;
        logic [1:0]       mode;
        logic [LEN_W-1:0] len0;
        logic [LEN_W-1:0] len1;
        logic [1:0]       exp_gnt;
        int               exp_len;
        logic             exp_mode;
        logic [2:0]       exp_result;
    } vec_t;

    vec_t vecs[8];

    // Issues one request from IDLE and follows the run through DONE into IDLE.
    task automatic run_vec(input vec_t v, input int idx);
        check("idle_busy", busy, 1'b0);
        req = v.req; req_mode = v.mode; req_len0 = v.len0; req_len1 = v.len1;
        tick();
        req = 2'b00;
        for (int j = 1; j <= v.exp_len; j++) begin
            check("run_gnt", gnt, v.exp_gnt);
            check("run_busy", busy, 1'b1);
            check("run_ctr_reset", ctr_reset, 1'b0);
            check("run_done", done, 2'b00);
            check("run_mode", ctr_mode, v.exp_mode);
            check("run_count", ctr_count, seq(j - 1, v.exp_mode));
            tick();
        end
        check("done_gnt", gnt, v.exp_gnt);
        check("done_pulse", done, v.exp_gnt);
        check("done_ctr_reset", ctr_reset, 1'b1);
        check("done_result", result, v.exp_result);
        tick();
        check("post_busy", busy, 1'b0);
        check("post_gnt", gnt, 2'b00);
        check("post_done", done, 2'b00);
        check("post_result_held", result, v.exp_result);
        $display("run %0d: req=%b gnt=%b len=%0d mode=%b result=%b", idx, v.req, v.exp_gnt,
                 v.exp_len, v.exp_mode, result);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //        req    mode   len0   len1   gnt    L   mode  result
        vecs[0] = '{2'b01, 2'b00, 4'd5,  4'd0,  2'b01, 5,  1'b0, 3'b101};
        vecs[1] = '{2'b10, 2'b10, 4'd0,  4'd10, 2'b10, 10, 1'b1, 3'b011};
        vecs[2] = '{2'b01, 2'b00, 4'd0,  4'd3,  2'b01, 0,  1'b0, 3'b000};
        vecs[3] = '{2'b11, 2'b11, 4'd3,  4'd7,  2'b10, 7,  1'b1, 3'b100};
        vecs[4] = '{2'b11, 2'b01, 4'd3,  4'd7,  2'b01, 3,  1'b1, 3'b010};
        vecs[5] = '{2'b10, 2'b00, 4'd0,  4'd15, 2'b10, 15, 1'b0, 3'b111};
        vecs[6] = '{2'b01, 2'b10, 4'd8,  4'd0,  2'b01, 8,  1'b0, 3'b000};
        vecs[7] = '{2'b10, 2'b10, 4'd0,  4'd1,  2'b10, 1,  1'b1, 3'b001};

        // Reset state, then release with no requests.
        repeat (3) tick();
        check("rst_gnt", gnt, 2'b00);
        check("rst_done", done, 2'b00);
        check("rst_ctr_reset", ctr_reset, 1'b1);
        check("rst_ctr_mode", ctr_mode, 1'b0);
        check("rst_result", result, 3'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_seq_err", seq_err, 1'b0);
        reset = 1'b1;
        repeat (3) tick();
        check("idle_gnt", gnt, 2'b00);
        check("idle_ctr_reset", ctr_reset, 1'b1);
        check("idle_busy0", busy, 1'b0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);
        check("clean_seq_err", seq_err, 1'b0);

        // Both requesters held: grants alternate with one IDLE cycle between runs.
        req = 2'b11; req_mode = 2'b00; req_len0 = 4'd2; req_len1 = 4'd2;
        for (int r = 0; r < 4; r++) begin
            logic [1:0] eg;
            eg = (r % 2 == 1) ? 2'b10 : 2'b01;
            check("fair_idle", busy, 1'b0);
            tick();
            check("fair_gnt1", gnt, eg);
            tick();
            check("fair_gnt2", gnt, eg);
            tick();
            check("fair_done", done, eg);
            check("fair_result", result, 3'd2);
            tick();
            $display("fair run %0d: gnt=%b", r, eg);
        end
        req = 2'b00;
        tick();
        check("fair_end_busy", busy, 1'b0);

        // Reset mid-run: immediate reset values, no done, pointer favours requester 0 again.
        req = 2'b01; req_mode = 2'b01; req_len0 = 4'd8;
        tick();
        req = 2'b00;
        check("mid_mode_pre", ctr_mode, 1'b1);
        tick(); tick();
        reset = 1'b0;
        #1;
        check("mid_gnt", gnt, 2'b00);
        check("mid_busy", busy, 1'b0);
        check("mid_ctr_reset", ctr_reset, 1'b1);
        check("mid_ctr_mode", ctr_mode, 1'b0);
        check("mid_result", result, 3'd0);
        check("mid_done", done, 2'b00);
        tick(); tick();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("mid_no_done", done, 2'b00);
            check("mid_idle", busy, 1'b0);
        end
        req = 2'b11; req_len0 = 4'd1; req_len1 = 4'd1; req_mode = 2'b00;
        tick();
        req = 2'b00;
        check("mid_rr_gnt", gnt, 2'b01);
        tick();
        check("mid_rr_done", done, 2'b01);
        tick();
        $display("mid-run reset: aborted without done, next tie granted to 0");

        // Corrupt the counter in the third RUN cycle.
        req = 2'b01; req_mode = 2'b00; req_len0 = 4'd6;
        tick();
        req = 2'b00;
        tick();
        tick();
        force_en = 1'b1; force_val = 3'b111;
        check("seq_before", seq_err, 1'b0);
        tick();
        force_en = 1'b0;
        check("seq_set", seq_err, SEQ_EN);
        tick();
        check("seq_hold1", seq_err, SEQ_EN);
        tick();
        tick();
        check("seq_done_result", result, 3'd6);
        check("seq_hold2", seq_err, SEQ_EN);
        tick();
        check("seq_hold_idle", seq_err, SEQ_EN);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("seq_cleared", seq_err, 1'b0);

        // Mismatch and err_clr in the same cycle: the set wins.
        req = 2'b01; req_len0 = 4'd3;
        tick();
        req = 2'b00;
        force_en = 1'b1; force_val = 3'b101; err_clr = 1'b1;
        tick();
        force_en = 1'b0; err_clr = 1'b0;
        check("seq_set_wins", seq_err, SEQ_EN);
        tick(); tick(); tick();
        check("seq_end_busy", busy, 1'b0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("seq_cleared2", seq_err, 1'b0);
        $display("sequence check: seq_err behaviour checked (enabled=%0d)", SEQ_EN);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
